audio_stream_bridge: RTL

- Parametrised bridge between audio_codec and the per-channel DSP `system` instances. Replaces the hard-wired left/right read/write sharing.
- Drains codec ADC frames into an input FIFO and presents them as a valid/ready stream to processing. Accepts processed frames into an output FIFO and feeds them to the codec DAC.
- Owns the codec read/write strobes; counts overrun and underrun events.

---
 rtl/audio_stream_bridge.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/audio_stream_bridge.sv
// Bridges codec ADC/DAC frame strobes to valid/ready processing streams through two frame FIFOs.
// Define AUDIO_BRIDGE_UNDERRUN_FILL_EN to write silence frames when the DAC is ready but no frame is queued.
module audio_stream_bridge #(
  parameter int unsigned NUM_CH = 2,
  parameter int unsigned W      = 24,
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                read_ready,
  input  logic [NUM_CH*W-1:0] codec_readdata,
  output logic                read,
  input  logic                write_ready,
  output logic [NUM_CH*W-1:0] codec_writedata,
  output logic                write,
  output logic                in_valid,
  output logic [NUM_CH*W-1:0] in_data,
  input  logic                in_ready,
  input  logic                out_valid,
  input  logic [NUM_CH*W-1:0] out_data,
  output logic                out_ready,
  output logic [CNT_W-1:0]    overrun_cnt,
  output logic [CNT_W-1:0]    underrun_cnt
);

  localparam int unsigned FW = NUM_CH * W;
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {R_IDLE, R_STROBE, R_GAP} rstate_t;
  typedef enum logic [1:0] {W_IDLE, W_STROBE, W_GAP} wstate_t;

  rstate_t r_rstate, w_rstate_nxt;
  wstate_t r_wstate, w_wstate_nxt;

  logic          r_read, r_write;
  logic [FW-1:0] r_codec_wdata, w_wdata_nxt;
  logic          r_in_valid, r_out_ready;
  logic [CNT_W-1:0] r_overrun_cnt, r_underrun_cnt;

  logic [FW-1:0] r_in_mem  [DEPTH];
  logic [FW-1:0] r_out_mem [DEPTH];
  logic [PW-1:0] r_in_wptr, r_in_rptr, r_out_wptr, r_out_rptr;
  logic [PW-1:0] w_in_wptr_nxt, w_in_rptr_nxt, w_in_cnt_nxt;
  logic [PW-1:0] w_out_wptr_nxt, w_out_rptr_nxt, w_out_cnt_nxt;

  logic w_rd_strobe, w_in_full, w_in_push, w_in_pop, w_overrun;
  logic w_out_empty, w_out_push, w_out_pop, w_underrun;

  // Read FSM next state: one strobe, then a gap so the codec can update read_ready
  always_comb begin
    w_rstate_nxt = r_rstate;
    case (r_rstate)
      R_IDLE:   if (read_ready) w_rstate_nxt = R_STROBE;
      R_STROBE: w_rstate_nxt = R_GAP;
      R_GAP:    w_rstate_nxt = R_IDLE;
      default:  w_rstate_nxt = R_IDLE;
    endcase
  end

  // Write FSM next state; the DAC frame is latched and popped on the IDLE->STROBE edge
  always_comb begin
    w_wstate_nxt = r_wstate;
    w_wdata_nxt  = r_codec_wdata;
    w_out_pop    = 1'b0;
    w_underrun   = 1'b0;
    case (r_wstate)
      W_IDLE: begin
        if (write_ready) begin
          if (!w_out_empty) begin
            w_wstate_nxt = W_STROBE;
            w_wdata_nxt  = r_out_mem[r_out_rptr[AW-1:0]];
            w_out_pop    = 1'b1;
          end else begin
            w_underrun = 1'b1;
`ifdef AUDIO_BRIDGE_UNDERRUN_FILL_EN
            w_wstate_nxt = W_STROBE;
            w_wdata_nxt  = '0;
`else
            w_wstate_nxt = W_IDLE;
`endif
          end
        end
      end
      W_STROBE: w_wstate_nxt = W_GAP;
      W_GAP:    w_wstate_nxt = W_IDLE;
      default:  w_wstate_nxt = W_IDLE;
    endcase
  end

  // Input FIFO: a pop in the same cycle frees the slot, so a full FIFO can still accept
  assign w_rd_strobe   = (r_rstate == R_STROBE);
  assign w_in_full     = (r_in_wptr[AW] != r_in_rptr[AW]) &&
                         (r_in_wptr[AW-1:0] == r_in_rptr[AW-1:0]);
  assign w_in_pop      = r_in_valid & in_ready;
  assign w_in_push     = w_rd_strobe & (~w_in_full | w_in_pop);
  assign w_overrun     = w_rd_strobe & ~w_in_push;
  assign w_in_wptr_nxt = w_in_push ? r_in_wptr + PW'(1) : r_in_wptr;
  assign w_in_rptr_nxt = w_in_pop  ? r_in_rptr + PW'(1) : r_in_rptr;
  assign w_in_cnt_nxt  = w_in_wptr_nxt - w_in_rptr_nxt;

  assign w_out_empty    = (r_out_wptr == r_out_rptr);
  assign w_out_push     = out_valid & r_out_ready;
  assign w_out_wptr_nxt = w_out_push ? r_out_wptr + PW'(1) : r_out_wptr;
  assign w_out_rptr_nxt = w_out_pop  ? r_out_rptr + PW'(1) : r_out_rptr;
  assign w_out_cnt_nxt  = w_out_wptr_nxt - w_out_rptr_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rstate <= R_IDLE;
      r_wstate <= W_IDLE;
    end else begin
      r_rstate <= w_rstate_nxt;
      r_wstate <= w_wstate_nxt;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_read         <= 1'b0;
      r_write        <= 1'b0;
      r_codec_wdata  <= '0;
      r_in_wptr      <= '0;
      r_in_rptr      <= '0;
      r_out_wptr     <= '0;
      r_out_rptr     <= '0;
      r_in_valid     <= 1'b0;
      r_out_ready    <= 1'b1;
      r_overrun_cnt  <= '0;
      r_underrun_cnt <= '0;
    end else begin
      r_read        <= (w_rstate_nxt == R_STROBE);
      r_write       <= (w_wstate_nxt == W_STROBE);
      r_codec_wdata <= w_wdata_nxt;
      r_in_wptr     <= w_in_wptr_nxt;
      r_in_rptr     <= w_in_rptr_nxt;
      r_out_wptr    <= w_out_wptr_nxt;
      r_out_rptr    <= w_out_rptr_nxt;
      r_in_valid    <= (w_in_cnt_nxt != '0);
      r_out_ready   <= (w_out_cnt_nxt != PW'(DEPTH));
      if (w_overrun && (r_overrun_cnt != CNT_MAX))
        r_overrun_cnt <= r_overrun_cnt + CNT_W'(1);
      if (w_underrun && (r_underrun_cnt != CNT_MAX))
        r_underrun_cnt <= r_underrun_cnt + CNT_W'(1);
    end
  end

  // Frame storage carries no reset; validity lives in the pointers
  always_ff @(posedge clk) begin
    if (w_in_push)  r_in_mem[r_in_wptr[AW-1:0]]   <= codec_readdata;
    if (w_out_push) r_out_mem[r_out_wptr[AW-1:0]] <= out_data;
  end

  assign read            = r_read;
  assign write           = r_write;
  assign codec_writedata = r_codec_wdata;
  assign in_valid        = r_in_valid;
  assign in_data         = r_in_mem[r_in_rptr[AW-1:0]];
  assign out_ready       = r_out_ready;
  assign overrun_cnt     = r_overrun_cnt;
  assign underrun_cnt    = r_underrun_cnt;

endmodule
